// File: rtl/seg7_pkg.sv
// Seven-segment codes shared by the decoder and the counter.
// Codes are active-low, bit order gfedcba (bit 0 = segment a).
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'b1111111;

  localparam seg7_t SEG7_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Single-digit BCD to active-low seven-segment decoder, purely combinational.
// Non-decimal BCD codes (10..15) show as blank.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output seg7_t      seg
);

  // Look up the segment pattern, forcing blank when requested.
  always_comb begin
    seg = SEG7_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG7_DIGIT[0];
        4'd1:    seg = SEG7_DIGIT[1];
        4'd2:    seg = SEG7_DIGIT[2];
        4'd3:    seg = SEG7_DIGIT[3];
        4'd4:    seg = SEG7_DIGIT[4];
        4'd5:    seg = SEG7_DIGIT[5];
        4'd6:    seg = SEG7_DIGIT[6];
        4'd7:    seg = SEG7_DIGIT[7];
        4'd8:    seg = SEG7_DIGIT[8];
        4'd9:    seg = SEG7_DIGIT[9];
        default: seg = SEG7_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_modulo_counter.sv
// Modulo-N up/down counter stage for timekeeping chains. Keeps a binary count
// and a BCD copy in lockstep, drives active-low seven-segment digits one cycle
// behind the count, and pulses carry_out on wrap/borrow for the next stage.
module bcd_modulo_counter
  import seg7_pkg::*;
#(
  parameter int   MODULO     = 60,
  parameter int   DIGITS     = 2,
  parameter bit   BLANK_LEAD = 1'b0,
  localparam int  W          = $clog2(MODULO)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  tick_in,
  input  logic                  clear,
  input  logic                  hold,
  input  logic                  down,
  input  logic                  load,
  input  logic [W-1:0]          load_value,
  output logic [W-1:0]          count,
  output logic                  carry_out,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BW = 4 * DIGITS;
  localparam logic [W-1:0] TOP_V = W'(MODULO - 1);

  if (DIGITS < 1 || DIGITS > 4 || MODULO < 2 || MODULO > 10**DIGITS) begin : g_bad_params
    $error("bcd_modulo_counter: illegal MODULO/DIGITS combination");
  end

  // Binary to BCD by shift-add-3; callers guarantee the value fits in DIGITS.
  function automatic logic [BW-1:0] to_bcd(input logic [W-1:0] bin);
    logic [BW-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
      end
      r = {r[BW-2:0], bin[i]};
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (b) begin
        if (r[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] seg_reset_value();
    logic [7*DIGITS-1:0] r;
    for (int k = 0; k < DIGITS; k++) begin
      r[7*k +: 7] = (BLANK_LEAD && k > 0) ? SEG7_BLANK : SEG7_DIGIT[0];
    end
    return r;
  endfunction

  localparam logic [7*DIGITS-1:0] SEG_RST = seg_reset_value();

  logic [BW-1:0]       bcd;
  logic [W-1:0]        count_d;
  logic [BW-1:0]       bcd_d;
  logic                carry_d;
  logic [DIGITS-1:0]   blank;
  logic                upper_zero;
  logic [7*DIGITS-1:0] seg_d;

  // Next count/BCD/carry with priority clear > load > hold > tick.
  always_comb begin
    count_d = count;
    bcd_d   = bcd;
    carry_d = 1'b0;
    if (clear) begin
      count_d = '0;
      bcd_d   = '0;
    end else if (load) begin
      if (load_value <= TOP_V) begin
        count_d = load_value;
        bcd_d   = to_bcd(load_value);
      end
    end else if (hold) begin
      count_d = count;
    end else if (tick_in) begin
      if (!down) begin
        if (count == TOP_V) begin
          count_d = '0;
          bcd_d   = '0;
          carry_d = 1'b1;
        end else begin
          count_d = count + W'(1);
          bcd_d   = bcd_inc(bcd);
        end
      end else begin
        if (count == '0) begin
          count_d = TOP_V;
          bcd_d   = to_bcd(TOP_V);
          carry_d = 1'b1;
        end else begin
          count_d = count - W'(1);
          bcd_d   = bcd_dec(bcd);
        end
      end
    end
  end

  // A non-units digit blanks when it and every digit above it are zero.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (bcd[4*k +: 4] == 4'd0);
      blank[k]   = BLANK_LEAD && upper_zero;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_to_seg7 u_dec (
      .bcd   (bcd[4*k +: 4]),
      .blank (blank[k]),
      .seg   (seg_d[7*k +: 7])
    );
  end

  // State and display registers; the display follows the BCD digits by one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      bcd       <= '0;
      carry_out <= 1'b0;
      seg       <= SEG_RST;
    end else begin
      count     <= count_d;
      bcd       <= bcd_d;
      carry_out <= carry_d;
      seg       <= seg_d;
    end
  end

endmodule

// File: doc/bcd_modulo_counter.md
Name: bcd_modulo_counter

Overview:
- Parametrised modulo-N counter for timekeeping chains (seconds → minutes → hours). It drives DIGITS active-low seven-segment displays and emits a one-cycle carry/borrow pulse to cascade into the next stage.
- It is the successor to the fixed 60-second stage and adds:
  - count direction (up/down)
  - synchronous load
  - hold
  - leading-zero blanking
  - an asynchronous reset
- Stages are cascaded by wiring carry_out of one stage to tick_in of the next. All stages share the same clock.

Parameters:
- MODULO, 60, count range 0..MODULO-1. Legal when 2 ≤ MODULO ≤ 10**DIGITS; elaboration error otherwise.
- DIGITS, 2, number of decimal digits displayed (1..4).
- BLANK_LEAD, 0, when 1, leading zero digits are blanked (the units digit is never blanked).
- W, $clog2(MODULO), width of the binary count. Derived; not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- tick_in  in  1  count enable; one-cycle pulse from the prescaler or the previous stage's carry_out.
- clear  in  1  synchronous clear to 0 (the stage's "zera" function).
- hold  in  1  freezes the count; ticks arriving while held are discarded, not queued.
- down  in  1  0 = count up, 1 = count down.
- load  in  1  synchronous load of load_value.
- load_value  in  W  value to load, binary.
- count  out  W  current count, binary, registered.
- carry_out  out  1  one-cycle pulse on wrap (up) or borrow (down).
- seg  out  7*DIGITS  active-low segments. Digit k occupies seg[7k+6:7k]; bit order within a digit, LSB first, is a,b,c,d,e,f,g. Digit 0 is the units digit.

Behaviour:
- Reset (reset_n=0, asynchronous): count=0, BCD digits=0, carry_out=0, seg = "0" on every digit (7'b1000000), or blank (7'b1111111) on non-units digits when BLANK_LEAD=1. Reset takes effect immediately, overriding any operation in progress.
- Priority at each rising edge is clear > load > hold > tick_in.
  - clear=1: count←0; carry_out←0.
  - load=1: if load_value < MODULO, count←load_value; if load_value ≥ MODULO, count is unchanged (ignored). carry_out←0.
  - hold=1: count unchanged; carry_out←0.
  - tick_in=1, down=0: if count==MODULO-1, count←0 and carry_out←1; else count←count+1 and carry_out←0.
  - tick_in=1, down=1: if count==0, count←MODULO-1 and carry_out←1; else count←count-1 and carry_out←0.
  - Otherwise: count unchanged; carry_out←0.
- carry_out is registered and high for exactly one cycle, in the same cycle that count first shows the wrapped value. Back-to-back ticks can therefore produce carry pulses on consecutive cycles (e.g. with MODULO=2).
- BCD digit registers are updated in lockstep with count using per-digit ±1 with carry/borrow. No divide or modulo operators are allowed in RTL. The BCD value always equals count.
- Load and wrap-down targets (load_value, MODULO-1) are converted to BCD by a combinational shift-add-3 conversion.
- seg is registered from the BCD digits, so it lags count by one cycle (latency 1).
- Blanking (BLANK_LEAD=1): digit k>0 is blanked when it and all higher digits are 0.
- Decode codes, gfedcba, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Inputs are synchronous to clock; this block contains no synchronisers.

Decomposition:
- Package seg7_pkg holds:
  - localparam array SEG7_DIGIT[0:9] with the codes above
  - SEG7_BLANK
  - typedef seg7_t (logic [6:0])
- Sub-module bcd_to_seg7: 4-bit BCD plus blank input → seg7_t, purely combinational. Instantiated DIGITS times in a generate loop.
- Binary/BCD counting and the shift-add-3 conversion stay in bcd_modulo_counter.

Test Plan:
- Reset: assert reset_n=0 mid-count at count=37 → count=0, carry_out=0 immediately (asynchronously); one cycle after release, seg=={1000000,1000000}.
- Up wrap (MODULO=60): load 58, apply 2 ticks → count 59 then 0; carry_out=1 only in the cycle count==0; after 1 more cycle, seg shows "00".
- Down borrow: load 0, down=1, one tick → count=59, carry_out pulse; seg tens=0010010 ("5"), units=0010000 ("9").
- Priority: clear=1, load=1 (load_value=12) and tick_in=1 in the same cycle → count=0. Next cycle: load=1, hold=1 → count=12. Load with load_value=60 → count unchanged.
- Hold: hold=1 during 5 ticks → count and seg unchanged, carry_out=0. After hold releases, one tick → count+1.
- Cascade (a 60-stage feeding a 24-stage, BLANK_LEAD=1): 1440 ticks → the 24-stage counts 0→23→0 with a single carry at the 1440th tick. At hour=5, the hours tens digit is 1111111 (blank).
